// File: rtl/follower_amp_pkg.sv
// -----------------------------------------------------------------------------
// follower_amp_pkg
// Shared types and helpers for the follower_amp time-multiplexing scheduler.
//   fas_state_t : scheduler FSM states (IDLE, SETTLE, ACTIVE, GAP)
//   cnt_width() : width of the settle/gap/hold counters, sized so the largest
//                 of the three cycle parameters fits
// -----------------------------------------------------------------------------
package follower_amp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2,
    GAP    = 2'd3
  } fas_state_t;

  function automatic int cnt_width(input int settle_cycles,
                                   input int gap_cycles,
                                   input int max_hold);
    int m;
    m = settle_cycles;
    if (gap_cycles > m) m = gap_cycles;
    if (max_hold > m) m = max_hold;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/follower_amp_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set request at or after the
// pointer, wrapping at NUM_REQ.
//   req        in  [NUM_REQ-1:0] : request vector
//   ptr        in  [IDX_W-1:0]   : highest-priority index this round
//   winner     out [NUM_REQ-1:0] : one-hot winner, zero when no request
//   winner_idx out [IDX_W-1:0]   : index of the winner (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx
);

  logic           found;
  logic [IDX_W:0] cand;   // one extra bit so ptr+i cannot overflow before wrap

  // NOTE: every variable written here gets a default first, otherwise the
  // paths that skip an assignment would infer a latch.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) cand = cand - (IDX_W + 1)'(NUM_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                     = 1'b1;
        winner_idx                = cand[IDX_W-1:0];
        winner[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/follower_amp_sched.sv
// -----------------------------------------------------------------------------
// follower_amp_sched
// Time-multiplexes the shared follower_amp buffer between NUM_REQ requesters.
// Round-robin arbitration, one-hot analog mux select, break-before-make gap,
// settling delay before rdy, optional maximum hold time with timeout pulse.
//   clk      in  : clock, all state on rising edge
//   rst      in  : asynchronous active-high reset
//   en       in  : global enable; low releases the owner and blocks grants
//   req      in  [NUM_REQ-1:0] : level requests, held until done
//   gnt      out [NUM_REQ-1:0] : one-hot current owner
//   mux_sel  out [NUM_REQ-1:0] : analog mux select, identical to gnt
//   amp_ena  out : amplifier enable
//   rdy      out : amplifier output settled for the current owner
//   timeout  out : one-cycle pulse when MAX_HOLD forces a release
//   busy     out : high whenever the FSM is not IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module follower_amp_sched
  import follower_amp_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int GAP_CYCLES    = 2,
  parameter int MAX_HOLD      = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] mux_sel,
  output logic               amp_ena,
  output logic               rdy,
  output logic               timeout,
  output logic               busy
);

  localparam int IDX_W     = $clog2(NUM_REQ);
  localparam int CNT_W     = cnt_width(SETTLE_CYCLES, GAP_CYCLES, MAX_HOLD);
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  fas_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;      // settle / gap down-counter
  logic [CNT_W-1:0]   hold_q, hold_d;    // cycles spent in ACTIVE
  logic [IDX_W-1:0]   ptr_q, ptr_d;      // round-robin pointer
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               amp_ena_q, amp_ena_d;
  logic               rdy_q, rdy_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               release_req;   // owner dropped its request or en fell
  logic               hold_expired;
  logic               enter_gap;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .winner     (win_onehot),
    .winner_idx (win_idx)
  );

  assign release_req  = !en || !req[owner_q];
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == CNT_W'(HOLD_LAST));

  // ---------------------------------------------------------------------------
  // State register and output/datapath flops
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      amp_ena_q <= 1'b0;
      rdy_q     <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      amp_ena_q <= amp_ena_d;
      rdy_q     <= rdy_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en && (|req)) state_d = SETTLE;
      SETTLE:  if (release_req) state_d = GAP;
               else if (cnt_q == '0) state_d = ACTIVE;
      // A voluntary release takes priority over a simultaneous hold expiry,
      // so no timeout is reported when the owner was leaving anyway.
      ACTIVE:  if (release_req || hold_expired) state_d = GAP;
      GAP:     if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values (registered above)
  // ---------------------------------------------------------------------------
  assign enter_gap = (state_q == SETTLE || state_q == ACTIVE) && (state_d == GAP);

  always_comb begin
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    amp_ena_d = amp_ena_q;
    rdy_d     = rdy_q;
    timeout_d = 1'b0;
    busy_d    = (state_d != IDLE);

    case (state_q)
      IDLE: begin
        if (state_d == SETTLE) begin
          gnt_d     = win_onehot;
          owner_d   = win_idx;
          amp_ena_d = 1'b1;
          cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (state_d == ACTIVE) begin
          rdy_d  = 1'b1;
          hold_d = '0;
        end else if (state_d == SETTLE) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (state_d == ACTIVE) hold_d = hold_q + CNT_W'(1);
      end
      GAP: begin
        if (state_d == GAP) cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase

    // Break-before-make: mux opens and amp turns off together on GAP entry;
    // the pointer moves past the owner that just left.
    if (enter_gap) begin
      gnt_d     = '0;
      amp_ena_d = 1'b0;
      rdy_d     = 1'b0;
      cnt_d     = CNT_W'(GAP_CYCLES - 1);
      ptr_d     = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
      timeout_d = (state_q == ACTIVE) && !release_req;
    end
  end

  assign gnt     = gnt_q;
  assign mux_sel = gnt_q;
  assign amp_ena = amp_ena_q;
  assign rdy     = rdy_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_follower_amp_sched.sv
// -----------------------------------------------------------------------------
// tb_follower_amp_sched
// Directed bench for follower_amp_sched (NUM_REQ=4, SETTLE=16, GAP=2,
// MAX_HOLD=4). Inputs change and outputs are sampled 1 time unit after each
// rising edge; expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_follower_amp_sched;

  localparam int NUM_REQ       = 4;
  localparam int SETTLE_CYCLES = 16;
  localparam int GAP_CYCLES    = 2;
  localparam int MAX_HOLD      = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] mux_sel;
  logic               amp_ena;
  logic               rdy;
  logic               timeout;
  logic               busy;

  int n_cmp = 0;
  int n_mis = 0;

  follower_amp_sched #(
    .NUM_REQ       (NUM_REQ),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES),
    .MAX_HOLD      (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .mux_sel (mux_sel),
    .amp_ena (amp_ena),
    .rdy     (rdy),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  int zero_cnt = 0;
  always @(posedge clk) begin
    if (mux_sel == '0) zero_cnt <= (zero_cnt < 1000) ? zero_cnt + 1 : zero_cnt;
    else               zero_cnt <= 0;
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_mux_eq: assert property (@(posedge clk) disable iff (rst) mux_sel == gnt);
  a_rdy_amp: assert property (@(posedge clk) disable iff (rst) rdy |-> amp_ena);
  a_amp_off: assert property (@(posedge clk) disable iff (rst) (mux_sel == '0) |-> !amp_ena);
  a_bbm: assert property (@(posedge clk) disable iff (rst)
                          (mux_sel != '0 && $past(mux_sel) == '0) |-> zero_cnt >= GAP_CYCLES);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded waits; an expired bound is reported as a failed comparison.
  task automatic wait_rdy(input string tag);
    int k = 0;
    while (!rdy && k < 40) begin step(); k++; end
    check(tag, 32'(rdy), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 40) begin step(); k++; end
    check(tag, 32'(busy), 32'd0);
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    logic seen_a, seen_b;
    int exp_order [4] = '{1, 2, 3, 0};
    int n_grants, n_to, zero_run;
    logic [NUM_REQ-1:0] prev_gnt;

    rst = 1'b1; en = 1'b0; req = '0;
    step(); step();
    check("rst_gnt",     32'(gnt),     32'h0);
    check("rst_mux",     32'(mux_sel), 32'h0);
    check("rst_amp",     32'({amp_ena, rdy, timeout, busy}), 32'h0);

    // Settle latency: req[2] alone, pointer 0 -> owner 2.
    rst = 1'b0; en = 1'b1; req = 4'b0100;
    step();
    check("settle_gnt",  32'(gnt),     32'b0100);
    check("settle_mux",  32'(mux_sel), 32'b0100);
    check("settle_amp",  32'(amp_ena), 32'd1);
    check("settle_rdy0", 32'(rdy),     32'd0);
    check("settle_busy", 32'(busy),    32'd1);
    k = 0;
    while (!rdy && k < 40) begin step(); k++; end
    check("settle_edges", 32'(k), 32'(SETTLE_CYCLES));

    // Held request: rdy lasts MAX_HOLD cycles, then timeout with first GAP cycle.
    k = 0;
    while (rdy && k < 40) begin k++; step(); end
    check("hold_cycles", 32'(k),       32'(MAX_HOLD));
    check("to_pulse",    32'(timeout), 32'd1);
    check("to_gnt",      32'(gnt),     32'h0);
    req = '0;
    step();
    check("to_onecyc",   32'(timeout), 32'd0);
    wait_idle("idle_after_to");

    // Abort in SETTLE: pointer now 3, req[1] wins.
    req = 4'b0010;
    step();
    check("abort_gnt", 32'(gnt), 32'b0010);
    seen_a = 1'b0;
    repeat (5) begin step(); seen_a |= rdy; end
    req = '0;
    step();
    check("abort_rel_gnt", 32'(gnt), 32'h0);
    check("abort_rel_amp", 32'(amp_ena), 32'd0);
    check("abort_gap_busy", 32'(busy), 32'd1);
    seen_b = timeout;
    repeat (3) begin step(); seen_a |= rdy; seen_b |= timeout; end
    check("abort_no_rdy", 32'(seen_a), 32'd0);
    check("abort_no_to",  32'(seen_b), 32'd0);
    wait_idle("idle_after_abort");

    // Release in ACTIVE: pointer now 2, only req[1] set -> owner 1.
    req = 4'b0010;
    step();
    check("rel_gnt", 32'(gnt), 32'b0010);
    wait_rdy("rel_wait_rdy");
    req = '0;
    step();
    check("rel_gnt0", 32'(gnt),     32'h0);
    check("rel_rdy0", 32'(rdy),     32'd0);
    check("rel_amp0", 32'(amp_ena), 32'd0);
    check("rel_no_to", 32'(timeout), 32'd0);
    // Re-grant: GAP (2 cycles) + IDLE -> gnt GAP_CYCLES+1 edges after release.
    req = 4'b0010;
    k = 0;
    do begin step(); k++; end while (gnt == '0 && k < 20);
    check("regrant_edges", 32'(k),   32'(GAP_CYCLES + 1));
    check("regrant_gnt",   32'(gnt), 32'b0010);

    // Global enable low in ACTIVE.
    wait_rdy("en_wait_rdy");
    en = 1'b0;
    step();
    check("en_rel_gnt", 32'(gnt), 32'h0);
    check("en_rel_rdy", 32'(rdy), 32'd0);
    check("en_rel_to",  32'(timeout), 32'd0);
    req = 4'b1111;
    seen_a = 1'b0;
    repeat (8) begin step(); seen_a |= (gnt != '0); end
    check("en_block_gnt", 32'(seen_a), 32'd0);
    check("en_block_busy", 32'(busy), 32'd0);
    en = 1'b1;
    step();
    check("en_resume_gnt", 32'(gnt), 32'b0100);   // pointer 2 after owner 1

    // Asynchronous reset mid-ACTIVE.
    wait_rdy("rst_wait_rdy");
    #3;
    rst = 1'b1;
    #1;
    check("arst_gnt",  32'(gnt),     32'h0);
    check("arst_mux",  32'(mux_sel), 32'h0);
    check("arst_outs", 32'({amp_ena, rdy, timeout, busy}), 32'h0);
    step(); step(); step();
    rst = 1'b0;
    req = 4'b0101;
    step();
    check("post_rst_gnt", 32'(gnt), 32'b0001);

    // Round-robin with all requests held: 0 (above), then 1,2,3,0.
    req = 4'b1111;
    prev_gnt = gnt;
    n_grants = 0; n_to = 0; zero_run = 0;
    k = 0;
    while (n_grants < 4 && k < 300) begin
      step(); k++;
      if (timeout) n_to++;
      if (gnt == '0) zero_run++;
      else if (prev_gnt == '0) begin
        check($sformatf("rr_order%0d", n_grants), 32'(onehot_idx(gnt)), 32'(exp_order[n_grants]));
        // GAP cycles plus the one IDLE cycle that makes the next grant.
        check($sformatf("rr_zero%0d", n_grants), 32'(zero_run), 32'(GAP_CYCLES + 1));
        n_grants++;
        zero_run = 0;
      end
      prev_gnt = gnt;
    end
    check("rr_grants",   32'(n_grants), 32'd4);
    check("rr_timeouts", 32'(n_to),     32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
